led_scan_controller: RTL

Time-multiplexing scheduler for the cycle computer's multi-digit LED display. It owns the shared segment bus (SegA–SegG, DP) and the active-low digit enables, and gives each digit a fixed time slot with an anti-ghosting blank interval at the start. Display data from the computation core is accepted through a req/ack handshake and takes effect only at frame boundaries, so no frame ever shows a torn value. It sits in comp_core between the display-value logic and the pad outputs.

---
 rtl/led_pkg.sv | 22 ++
 rtl/seven_seg_decode.sv | 28 ++
 rtl/led_scan_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants for the LED scan path: seven-segment patterns ({A..G}, A in the MSB),
// special code values and the slot phase type.
package led_pkg;

  typedef enum logic {BLANK, ON} phase_t;

  localparam logic [3:0] CODE_MINUS = 4'hA;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seven_seg_decode.sv
// 4-bit display code to {A..G} segment pattern; purely combinational, no handshake.
// Codes above CODE_MINUS decode to the blank pattern.
module seven_seg_decode
  import led_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0:       seg = SEG_0;
      4'h1:       seg = SEG_1;
      4'h2:       seg = SEG_2;
      4'h3:       seg = SEG_3;
      4'h4:       seg = SEG_4;
      4'h5:       seg = SEG_5;
      4'h6:       seg = SEG_6;
      4'h7:       seg = SEG_7;
      4'h8:       seg = SEG_8;
      4'h9:       seg = SEG_9;
      CODE_MINUS: seg = SEG_MINUS;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led_scan_controller.sv
// Multiplexed LED scan with blank-first slots; pins lag counters by 1 cycle.
// LoadReq waits for the next frame boundary; LoadAck pulses one cycle on capture.
module led_scan_controller
  import led_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 64,
  parameter int BLANK_TICKS     = 4
)
(
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DpMask,
  input  logic                    LzbEnable,
  input  logic                    Blank,
  input  logic                    LoadReq,
  output logic                    LoadAck,
  output logic                    SegA,
  output logic                    SegB,
  output logic                    SegC,
  output logic                    SegD,
  output logic                    SegE,
  output logic                    SegF,
  output logic                    SegG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   nDigit
);

  localparam int CntW = $clog2(TICKS_PER_DIGIT);
  localparam int DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CntW-1:0]         cnt;
  logic [DigW-1:0]         dig;
  logic [4*NUM_DIGITS-1:0] shadowValue;
  logic [NUM_DIGITS-1:0]   shadowDp;
  logic                    frameEnd;
  phase_t                  phase;

  assign frameEnd = (cnt == CntW'(TICKS_PER_DIGIT - 1)) && (dig == DigW'(NUM_DIGITS - 1));
  assign phase    = (cnt < CntW'(BLANK_TICKS)) ? BLANK : ON;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt         <= '0;
      dig         <= '0;
      shadowValue <= '0;
      shadowDp    <= '0;
      LoadAck     <= 1'b0;
    end else begin
      cnt     <= cnt + CntW'(1);
      LoadAck <= frameEnd && LoadReq;
      if (cnt == CntW'(TICKS_PER_DIGIT - 1)) begin
        dig <= (dig == DigW'(NUM_DIGITS - 1)) ? '0 : dig + DigW'(1);
      end
      // Capture only at the frame edge, so a whole frame always shows one value
      if (frameEnd && LoadReq) begin
        shadowValue <= Value;
        shadowDp    <= DpMask;
      end
    end
  end

  // zeroFrom[k]: digits k..NUM_DIGITS-1 all hold code 0
  logic [NUM_DIGITS-1:0] zeroFrom;
  logic                  allZero;

  always_comb begin
    zeroFrom = '0;
    allZero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      allZero     = allZero && (shadowValue[4*k +: 4] == 4'h0);
      zeroFrom[k] = allZero;
    end
  end

  logic [3:0] code;
  logic [6:0] segRaw;
  logic       digitDark;
  logic       dpOn;

  assign code = shadowValue[4*dig +: 4];

  seven_seg_decode uDecode (
    .code (code),
    .seg  (segRaw)
  );

  assign digitDark = (segRaw == SEG_BLANK) || (LzbEnable && (dig != '0) && zeroFrom[dig]);
  assign dpOn      = shadowDp[dig];

  logic [6:0]            segNext;
  logic                  dpNext;
  logic [NUM_DIGITS-1:0] nDigitNext;

  always_comb begin
    segNext    = SEG_BLANK;
    dpNext     = 1'b0;
    nDigitNext = '1;
    if (phase == ON && !Blank) begin
      dpNext = dpOn;
      if (!digitDark) segNext = segRaw;
      // A dark digit is still enabled when it has to show its decimal point
      if (!digitDark || dpOn) nDigitNext = ~(NUM_DIGITS'(1) << dig);
    end
  end

  logic [6:0] segReg;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      segReg <= SEG_BLANK;
      DP     <= 1'b0;
      nDigit <= '1;
    end else begin
      segReg <= segNext;
      DP     <= dpNext;
      nDigit <= nDigitNext;
    end
  end

  assign {SegA, SegB, SegC, SegD, SegE, SegF, SegG} = segReg;

endmodule
